// File: rtl/spi_sram_burst_master.sv
// SPI mode-0 initiator for a 23LC-style serial SRAM: byte requests become
// command/address/data frames, and consecutive same-op requests continue one frame.
module spi_sram_burst_master #(
  parameter int ADDR_BYTES     = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int CS_HIGH_CYCLES = 2,
  localparam int AW = 8 * ADDR_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_wdata,
  output logic          rsp_valid,
  output logic [7:0]    rsp_rdata,
  output logic          sclk,
  output logic          cs_n,
  output logic          mosi,
  input  logic          miso
);

  localparam int SW   = 8 + AW;
  localparam int BW   = $clog2(SW);
  localparam int WMAX = (HOLD_CYCLES > CS_HIGH_CYCLES) ? HOLD_CYCLES : CS_HIGH_CYCLES;
  localparam int WW   = $clog2(WMAX + 1);
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_HOLD, S_CSHIGH
  } state_t;

  state_t          state, state_nxt;
  logic            run;
  logic            phase;
  logic [BW-1:0]   bit_cnt;
  logic [BW-1:0]   bit_last_idx;
  logic [WW-1:0]   wait_cnt;
  logic            lat_wr;
  logic [AW-1:0]   lat_addr;
  logic [7:0]      lat_wdata;
  logic [SW-1:0]   tx_sh;
  logic [7:0]      rx_sh;
  logic            pend;
  logic            bit_state, bit_last, hold_done, cs_done, accept, seq_hit;

  assign bit_state    = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
  assign bit_last_idx = (state == S_ADDR) ? BW'(AW - 1) : BW'(7);
  assign bit_last     = bit_state && phase && (bit_cnt == bit_last_idx);
  assign hold_done    = (wait_cnt == WW'(HOLD_CYCLES - 1));
  assign cs_done      = (wait_cnt == WW'(CS_HIGH_CYCLES - 1));
  assign accept       = req_valid && req_ready;
  // The AW-bit add wraps exactly like the SRAM's internal address counter.
  assign seq_hit      = (req_wr == lat_wr) && (req_addr == lat_addr + AW'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept) state_nxt = S_CMD;
      S_CMD:    if (bit_last) state_nxt = S_ADDR;
      S_ADDR:   if (bit_last) state_nxt = S_DATA;
      S_DATA:   if (bit_last) state_nxt = S_HOLD;
      S_HOLD: begin
        if (accept)         state_nxt = seq_hit ? S_DATA : S_CSHIGH;
        else if (hold_done) state_nxt = S_CSHIGH;
      end
      S_CSHIGH: if (cs_done) state_nxt = pend ? S_CMD : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cs_n      = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    req_ready = 1'b0;
    unique case (state)
      S_IDLE: req_ready = run;
      S_CMD, S_ADDR, S_DATA: begin
        cs_n = 1'b0;
        sclk = phase;
        mosi = tx_sh[SW-1];
      end
      S_HOLD: begin
        cs_n      = 1'b0;
        req_ready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      phase     <= 1'b0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      pend      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      run       <= 1'b1;
      rsp_valid <= 1'b0;
      phase     <= bit_state ? ~phase : 1'b0;

      if ((state_nxt == state) && ((state == S_HOLD) || (state == S_CSHIGH)))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      // mosi advances at the end of each high phase, i.e. as sclk falls.
      if (bit_state && phase) begin
        bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
        tx_sh   <= {tx_sh[SW-2:0], 1'b0};
      end

      // Low->high phase edge is the one that raises sclk: sample miso here.
      if ((state == S_DATA) && !phase)
        rx_sh <= {rx_sh[6:0], miso};

      if ((state == S_ADDR) && bit_last)
        tx_sh <= {(lat_wr ? lat_wdata : 8'h00), AW'(0)};

      if ((state == S_DATA) && bit_last) begin
        rsp_valid <= 1'b1;
        if (!lat_wr) rsp_rdata <= rx_sh;
      end

      if ((state == S_CSHIGH) && cs_done)
        pend <= 1'b0;

      if (accept) begin
        lat_wr    <= req_wr;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        if ((state == S_HOLD) && seq_hit) begin
          tx_sh <= {(req_wr ? req_wdata : 8'h00), AW'(0)};
        end else begin
          tx_sh <= {(req_wr ? CMD_WRITE : CMD_READ), req_addr};
          pend  <= (state == S_HOLD);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_sram_burst_master.sv
// Directed bench for spi_sram_burst_master with a behavioural mode-0 serial
// SRAM on the SPI pins; expected values are hand-computed per step.
module tb_spi_sram_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        sclk, cs_n, mosi;
  logic        miso = 1'b0;

  spi_sram_burst_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- serial SRAM model (mode 0) ----------------
  logic [7:0]  mem [logic [23:0]];
  int          s_cnt = 0;
  logic [7:0]  s_cmd = '0;
  logic [23:0] s_addr = '0;
  logic [23:0] s_ptr = '0;
  logic [7:0]  s_byte = '0;
  int          hdr_cnt = 0;

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h3C;
  endfunction

  always @(negedge cs_n) s_cnt = 0;

  always @(posedge sclk) begin
    if (cs_n === 1'b0) begin
      if (s_cnt < 8)       s_cmd  = {s_cmd[6:0], mosi};
      else if (s_cnt < 32) s_addr = {s_addr[22:0], mosi};
      else                 s_byte = {s_byte[6:0], mosi};
      s_cnt++;
      if (s_cnt == 32) begin
        s_ptr = s_addr;
        hdr_cnt++;
      end else if (s_cnt > 32 && ((s_cnt - 32) % 8) == 0) begin
        if (s_cmd == 8'h02) mem[s_ptr] = s_byte;
        s_ptr = s_ptr + 24'd1;
      end
    end
  end

  always @(negedge sclk) begin
    logic [7:0] b;
    int idx;
    if (cs_n === 1'b0 && s_cnt >= 32 && s_cmd == 8'h03) begin
      b    = mem_rd(s_ptr);
      idx  = 7 - ((s_cnt - 32) % 8);
      miso = b[idx];
    end
  end

  // ---------------- pin monitor ----------------
  logic prev_cs = 1'b1;
  int   hi_len = 0, last_hi_len = 0;
  int   cs_fall_cyc = 0, cs_rise_cyc = 0, cs_falls = 0;
  int   rsp_cnt = 0, mosi_bad = 0;

  always @(negedge clk) begin
    if (cs_n && !prev_cs) begin
      cs_rise_cyc = cyc;
      hi_len = 0;
    end
    if (cs_n) hi_len++;
    if (!cs_n && prev_cs) begin
      cs_fall_cyc = cyc;
      cs_falls++;
      last_hi_len = hi_len;
    end
    prev_cs = cs_n;
    if (rsp_valid) rsp_cnt++;
    if (cs_n && mosi !== 1'b0) mosi_bad++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int acc_cyc = 0, rsp_cyc = 0;
  logic [7:0] rsp_data = '0;

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input logic wr, input logic [23:0] a, input logic [7:0] d);
    int n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n >= 300), 32'd0);
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rsp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 300);
    check("rsp_timeout", 32'(n >= 300), 32'd0);
    rsp_cyc  = cyc;
    rsp_data = rsp_rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] v_cs, v_rdy, v_rv;
    int h0, f0, r0;

    mem[24'h001234] = 8'hA5;
    mem[24'h000400] = 8'h11;
    mem[24'h000401] = 8'h22;
    mem[24'h000402] = 8'h33;
    mem[24'h000800] = 8'hC3;
    mem[24'hFFFFFF] = 8'h7E;
    mem[24'h000000] = 8'h81;
    mem[24'h000010] = 8'h4D;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_pins", {27'd0, cs_n, sclk, mosi, req_ready, rsp_valid}, 32'b10000);
    check("reset_rdata", rsp_rdata, 32'h00);
    rst_n = 1'b1;
    check("ready_before_edge", req_ready, 32'd0);
    @(negedge clk);
    check("ready_after_release", req_ready, 32'd1);

    // 1: single read of 0x001234, then HOLD expiry and CSHIGH window
    issue(1'b0, 24'h001234, 8'h00);
    wait_rsp();
    check("t1_cmd", s_cmd, 32'h03);
    check("t1_addr", s_addr, 32'h001234);
    check("t1_rdata", rsp_data, 32'hA5);
    check("t1_latency", rsp_cyc - cs_fall_cyc, 32'd80);
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      v_cs[i] = cs_n; v_rdy[i] = req_ready; v_rv[i] = rsp_valid;
    end
    check("t1_cs_after", v_cs, 32'b000111);
    check("t1_ready_after", v_rdy, 32'b111001);
    check("t1_rv_pulse", v_rv, 32'b000000);
    check("t1_rise", cs_rise_cyc - rsp_cyc, 32'd4);

    // 2: write 0x5A @0x200, then read back (op change inside HOLD)
    repeat (4) @(negedge clk);
    issue(1'b1, 24'h000200, 8'h5A);
    wait_rsp();
    check("t2_wcmd", s_cmd, 32'h02);
    check("t2_mem", mem_rd(24'h000200), 32'h5A);
    check("t2_rdata_held", rsp_data, 32'hA5);
    issue(1'b0, 24'h000200, 8'h00);
    wait_rsp();
    check("t2_rdata", rsp_data, 32'h5A);
    check("t2_cs_high", last_hi_len, 32'd2);
    check("t2_rcmd", s_cmd, 32'h03);
    check("t2_latency", rsp_cyc - cs_fall_cyc, 32'd80);

    // 3: sequential burst 0x400..0x402 in one cs_n window
    repeat (10) @(negedge clk);
    h0 = hdr_cnt; f0 = cs_falls;
    issue(1'b0, 24'h000400, 8'h00);
    wait_rsp();
    check("t3_b0", rsp_data, 32'h11);
    issue(1'b0, 24'h000401, 8'h00);
    wait_rsp();
    check("t3_b1", rsp_data, 32'h22);
    check("t3_lat1", rsp_cyc - acc_cyc, 32'd16);
    issue(1'b0, 24'h000402, 8'h00);
    wait_rsp();
    check("t3_b2", rsp_data, 32'h33);
    check("t3_lat2", rsp_cyc - acc_cyc, 32'd16);
    check("t3_headers", hdr_cnt - h0, 32'd1);
    check("t3_cs_windows", cs_falls - f0, 32'd1);

    // 4: non-sequential address inside HOLD
    repeat (10) @(negedge clk);
    issue(1'b0, 24'h000400, 8'h00);
    wait_rsp();
    check("t4_b0", rsp_data, 32'h11);
    issue(1'b0, 24'h000800, 8'h00);
    wait_rsp();
    check("t4_cs_high", last_hi_len, 32'd2);
    check("t4_addr", s_addr, 32'h000800);
    check("t4_cmd", s_cmd, 32'h03);
    check("t4_rdata", rsp_data, 32'hC3);

    // 5: address wrap 0xFFFFFF -> 0x000000 is sequential
    repeat (10) @(negedge clk);
    f0 = cs_falls;
    issue(1'b0, 24'hFFFFFF, 8'h00);
    wait_rsp();
    check("t5_top", rsp_data, 32'h7E);
    issue(1'b0, 24'h000000, 8'h00);
    wait_rsp();
    check("t5_wrap", rsp_data, 32'h81);
    check("t5_lat", rsp_cyc - acc_cyc, 32'd16);
    check("t5_cs_windows", cs_falls - f0, 32'd1);

    // 6: reset during the address phase, then a clean read
    repeat (10) @(negedge clk);
    issue(1'b0, 24'h000010, 8'h00);
    repeat (20) @(negedge clk);
    r0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_abort_pins", {28'd0, cs_n, sclk, mosi, rsp_valid}, 32'b1000);
    check("t6_abort_rdata", rsp_rdata, 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("t6_no_rsp", rsp_cnt - r0, 32'd0);
    check("t6_idle_cs", cs_n, 32'd1);
    issue(1'b0, 24'h000010, 8'h00);
    wait_rsp();
    check("t6_rdata", rsp_data, 32'h4D);
    check("t6_latency", rsp_cyc - cs_fall_cyc, 32'd80);

    repeat (10) @(negedge clk);
    check("mosi_idle_zero", mosi_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
